// File: rtl/rom_rd_pkg.sv
// FSM state encoding shared by the sequential ROM reader and its users.
package rom_rd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LAT  = 3'd2,
    PRES = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/rom_seq_reader.sv
// Walks COUNT ROM words from BASE and streams them out on valid/ready.
// Optional ROM_RD_CHKSUM_EN adds a running XOR checksum output.
module rom_seq_reader
  import rom_rd_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DW    = 16,
  parameter int BASE  = 0,
  parameter int COUNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bgn,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [AW-1:0] itr,
  output logic          busy,
  output logic          fin
`ifdef ROM_RD_CHKSUM_EN
  ,
  output logic [DW-1:0] chksum
`endif
);

  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [AW-1:0] LAST   = AW'(COUNT - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);

  if (COUNT < 1 || COUNT > 2**AW) begin : g_bad_count
    $error("rom_seq_reader: COUNT out of range 1..2**AW");
  end
  if (BASE < 0 || BASE > 2**AW - 1) begin : g_bad_base
    $error("rom_seq_reader: BASE out of range 0..2**AW-1");
  end

  state_t state, nxt;

  logic acc;
  assign acc = out_vld & out_rdy;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bgn) nxt = ADDR;
      ADDR: nxt = LAT;
      LAT:  nxt = PRES;
      PRES: if (acc) nxt = (itr == LAST) ? DONE : ADDR;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign fin  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= BASE_A;
      out_data <= '0;
      out_vld  <= 1'b0;
      itr      <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (bgn) begin
          rom_addr <= BASE_A;
          itr      <= '0;
        end
        LAT: begin
          out_data <= rom_data;
          out_vld  <= 1'b1;
        end
        PRES: if (acc) begin
          out_vld <= 1'b0;
          if (itr != LAST) begin
            itr      <= itr + ONE;
            rom_addr <= rom_addr + ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_RD_CHKSUM_EN
  // Cleared on each accepted start, then folds in every accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (state == IDLE && bgn) begin
      chksum <= '0;
    end else if (state == PRES && acc) begin
      chksum <= chksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Scoreboard bench: three reader instances with different BASE/COUNT,
// each fed by a 1-cycle-latency ROM holding 16'hA000+addr.
module tb_rom_seq_reader;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  itr;
    logic [3:0]  addr;
    logic        last;
  } exp_t;

  localparam int BASES[3] = '{0, 14, 0};
  localparam int CNTS[3]  = '{16, 4, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bgn[3];
  logic        rdy[3];
  logic [3:0]  addr_s[3];
  logic [15:0] rd[3];
  logic [15:0] odata[3];
  logic        vld[3];
  logic [3:0]  itr_s[3];
  logic        busy_s[3];
  logic        fin_s[3];
  logic [15:0] ck[3];

  exp_t q[3][$];
  logic fin_due[3];
  int   start_cyc[3];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd[0] <= 16'hA000 + 16'(addr_s[0]);
    rd[1] <= 16'hA000 + 16'(addr_s[1]);
    rd[2] <= 16'hA000 + 16'(addr_s[2]);
  end

`ifdef ROM_RD_CHKSUM_EN
  `define CKP(n) , .chksum(ck[n])
`else
  `define CKP(n)
  initial begin
    ck[0] = '0;
    ck[1] = '0;
    ck[2] = '0;
  end
`endif

  rom_seq_reader #(.AW(4), .DW(16), .BASE(0), .COUNT(16)) u0 (
    .clk(clk), .rst(rst), .bgn(bgn[0]), .rom_addr(addr_s[0]),
    .rom_data(rd[0]), .out_data(odata[0]), .out_vld(vld[0]),
    .out_rdy(rdy[0]), .itr(itr_s[0]), .busy(busy_s[0]), .fin(fin_s[0])
    `CKP(0)
  );

  rom_seq_reader #(.AW(4), .DW(16), .BASE(14), .COUNT(4)) u1 (
    .clk(clk), .rst(rst), .bgn(bgn[1]), .rom_addr(addr_s[1]),
    .rom_data(rd[1]), .out_data(odata[1]), .out_vld(vld[1]),
    .out_rdy(rdy[1]), .itr(itr_s[1]), .busy(busy_s[1]), .fin(fin_s[1])
    `CKP(1)
  );

  rom_seq_reader #(.AW(4), .DW(16), .BASE(0), .COUNT(3)) u2 (
    .clk(clk), .rst(rst), .bgn(bgn[2]), .rom_addr(addr_s[2]),
    .rom_data(rd[2]), .out_data(odata[2]), .out_vld(vld[2]),
    .out_rdy(rdy[2]), .itr(itr_s[2]), .busy(busy_s[2]), .fin(fin_s[2])
    `CKP(2)
  );

  // Monitor: pops on every accept, checks fin the cycle after the last one.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (fin_due[i] || fin_s[i]) begin
          nvec++;
          if (fin_s[i] !== fin_due[i]) begin
            nerr++;
            $display("FAIL fin%0d: got %b want %b", i, fin_s[i], fin_due[i]);
          end
          fin_due[i] = 1'b0;
        end
        if (vld[i] && rdy[i]) begin
          nvec++;
          if (q[i].size() == 0) begin
            nerr++;
            $display("FAIL word%0d: unexpected %h itr %0d", i, odata[i], itr_s[i]);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            if (odata[i] !== e.data || itr_s[i] !== e.itr || addr_s[i] !== e.addr) begin
              nerr++;
              $display("FAIL word%0d: got %h/%0d/%0d want %h/%0d/%0d", i,
                       odata[i], itr_s[i], addr_s[i], e.data, e.itr, e.addr);
            end
            if (e.last) fin_due[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic start(input int i);
    @(posedge clk);
    #1 bgn[i] = 1'b1;
    start_cyc[i] = cyc + 1;
    for (int k = 0; k < CNTS[i]; k++) begin
      exp_t e;
      e.addr = 4'((BASES[i] + k) % 16);
      e.data = 16'hA000 + 16'(e.addr);
      e.itr  = 4'(k);
      e.last = (k == CNTS[i] - 1);
      q[i].push_back(e);
    end
    @(posedge clk);
    #1 bgn[i] = 1'b0;
  endtask

  task automatic wait_fin(input int i, output int fc);
    fc = -1;
    for (int n = 0; n < 400 && fc < 0; n++) begin
      @(negedge clk);
      if (fin_s[i]) fc = cyc;
    end
    if (fc < 0) begin
      nvec++;
      nerr++;
      $display("FAIL timeout%0d: no fin, want fin", i);
    end
  endtask

  task automatic wait_itr(input int i, input logic [3:0] n, input logic v);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (itr_s[i] == n && vld[i] == v) return;
    end
    nvec++;
    nerr++;
    $display("FAIL wait%0d: itr %0d vld %b not reached", i, n, v);
  endtask

  initial begin
    int fc;
    for (int i = 0; i < 3; i++) begin
      bgn[i] = 1'b0;
      rdy[i] = 1'b1;
      fin_due[i] = 1'b0;
    end
    // 1. reset values
    #20;
    check("rst_addr0", 32'(addr_s[0]), 32'd0);
    check("rst_addr1", 32'(addr_s[1]), 32'd14);
    check("rst_data", 32'(odata[0]), 32'h0);
    check("rst_vld", 32'(vld[0] | vld[1]), 32'd0);
    check("rst_itr", 32'(itr_s[0]), 32'd0);
    check("rst_busy", 32'(busy_s[0] | busy_s[1]), 32'd0);
    check("rst_fin", 32'(fin_s[0]), 32'd0);
    #5 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_busy", 32'(busy_s[0]), 32'd0);

    // 2. full run, 3 cycles per word
    start(0);
    wait_fin(0, fc);
    check("run_lat", 32'(fc - start_cyc[0]), 32'd48);
`ifdef ROM_RD_CHKSUM_EN
    @(negedge clk);
    check("ck_full", 32'(ck[0]), 32'h0000);
`endif

    // 3. backpressure on word 3
    start(0);
    wait_itr(0, 4'd3, 1'b0);
    @(posedge clk);
    #1 rdy[0] = 1'b0;
    wait_itr(0, 4'd3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_data", 32'(odata[0]), 32'hA003);
      check("bp_vld", 32'(vld[0]), 32'd1);
      check("bp_addr", 32'(addr_s[0]), 32'd3);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    wait_fin(0, fc);

    // 4. wrapping base, plus bgn held high for two back-to-back runs
    start(1);
    wait_fin(1, fc);
    check("wrap_lat", 32'(fc - start_cyc[1]), 32'd12);
    @(posedge clk);
    #1 bgn[1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.addr = 4'((14 + k) % 16);
        e.data = 16'hA000 + 16'(e.addr);
        e.itr  = 4'(k);
        e.last = (k == 3);
        q[1].push_back(e);
      end
    end
    wait_fin(1, fc);
    @(negedge clk);
    @(negedge clk);
    check("held_busy", 32'(busy_s[1]), 32'd1);
    @(posedge clk);
    #1 bgn[1] = 1'b0;
    wait_fin(1, fc);

    // 5. bgn while busy ignored; reset in PRES of word 5
    start(0);
    repeat (4) @(posedge clk);
    #1 bgn[0] = 1'b1;
    @(posedge clk);
    #1 bgn[0] = 1'b0;
    wait_itr(0, 4'd5, 1'b0);
    @(posedge clk);
    #1 rdy[0] = 1'b0;
    wait_itr(0, 4'd5, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_vld", 32'(vld[0]), 32'd0);
    check("mid_busy", 32'(busy_s[0]), 32'd0);
    check("mid_fin", 32'(fin_s[0]), 32'd0);
    check("mid_itr", 32'(itr_s[0]), 32'd0);
    q[0].delete();
    fin_due[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy[0] = 1'b1;
    start(0);
    wait_fin(0, fc);
    check("restart_lat", 32'(fc - start_cyc[0]), 32'd48);

    // 6. short run
    start(2);
    wait_fin(2, fc);
    check("short_lat", 32'(fc - start_cyc[2]), 32'd9);
`ifdef ROM_RD_CHKSUM_EN
    repeat (2) @(negedge clk);
    check("ck_short", 32'(ck[2]), 32'hA003);
`endif

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) check("q_empty", 32'(q[i].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
